// File: rtl/instruction_fetch_pkg.sv
// Shared Argon core constants and the fetch-stage record type.
// Imported by the fetch stage and its prefetch FIFO.
package instruction_fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_fifo.sv
// Synchronous prefetch FIFO with flush, occupancy count and a head read
// straight from the storage registers. DEPTH must be a power of two.
module fetch_fifo
  import instruction_fetch_pkg::*;
#(
  parameter int               WIDTH      = 64,
  parameter int               DEPTH      = 4,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_pop    = pop && (count != '0);
    do_push   = push && ((count != CNT_W'(DEPTH)) || do_pop);
    head_data = mem[rd_ptr];
  end

  // Storage is reset so the head shows RESET_DATA until the first push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= RESET_DATA;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Argon RV32I fetch stage: credit-limited word requests, prefetch FIFO toward
// decode, and redirect handling that drops every response already in flight.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_instr_valid,
  output logic [31:0] o_instruction,
  output logic [31:0] o_pc,
  input  logic        i_decode_ready,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]      fetch_pc;
  logic [31:0]      resp_pc;
  logic [31:0]      held_addr;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] outstanding_next;
  logic [CNT_W-1:0] discard;
  logic [CNT_W-1:0] fifo_count;
  logic             started;
  logic             held;
  logic             stale;
  logic             credit_ok;
  logic             grant;
  logic             push;
  logic             pop;
  fetch_entry_t     push_entry;
  fetch_entry_t     head_entry;

  // A held request keeps its address even across redirects; 'stale' marks
  // that its eventual response belongs to the pre-redirect stream.
  always_comb begin
    credit_ok        = ({1'b0, outstanding} + {1'b0, fifo_count}) < (CNT_W + 1)'(FIFO_DEPTH);
    o_imem_req       = started && (held || credit_ok);
    o_imem_addr      = held ? held_addr : fetch_pc;
    grant            = o_imem_req && i_imem_gnt;
    outstanding_next = outstanding + CNT_W'(grant) - CNT_W'(i_imem_rvalid);
    redirect_pc      = align_pc(i_redirect_pc);
    o_instr_valid    = (fifo_count != '0);
    pop              = o_instr_valid && i_decode_ready;
    push             = i_imem_rvalid && (discard == '0) && !i_redirect;
    push_entry       = '{pc: resp_pc, instr: i_imem_rdata};
    o_pc             = head_entry.pc;
    o_instruction    = head_entry.instr;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      held_addr   <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      started     <= 1'b0;
      held        <= 1'b0;
      stale       <= 1'b0;
    end else begin
      started     <= 1'b1;
      held        <= o_imem_req && !i_imem_gnt;
      held_addr   <= o_imem_addr;
      outstanding <= outstanding_next;
      if (i_redirect) begin
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
        discard  <= outstanding_next;
        stale    <= o_imem_req && !i_imem_gnt;
      end else begin
        if (grant && !stale) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (grant) begin
          stale <= 1'b0;
        end
        if (push) begin
          resp_pc <= resp_pc + 32'd4;
        end
        discard <= discard + CNT_W'(grant && stale)
                           - CNT_W'(i_imem_rvalid && (discard != '0));
      end
    end
  end

  fetch_fifo #(
    .WIDTH      ($bits(fetch_entry_t)),
    .DEPTH      (FIFO_DEPTH),
    .RESET_DATA ({RESET_PC, NOP_INSTR})
  ) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (push),
    .pop       (pop),
    .flush     (i_redirect),
    .push_data (push_entry),
    .head_data (head_entry),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: memory model with configurable
// grant/latency, scoreboard of the expected PC stream, table of redirect targets.
module tb_instruction_fetch;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        i_clk   = 1'b0;
  logic        i_rst_n = 1'b1;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt     = 1'b0;
  logic        i_imem_rvalid  = 1'b0;
  logic [31:0] i_imem_rdata   = '0;
  logic        o_instr_valid;
  logic [31:0] o_instruction;
  logic [31:0] o_pc;
  logic        i_decode_ready = 1'b0;
  logic        i_redirect     = 1'b0;
  logic [31:0] i_redirect_pc  = '0;

  instruction_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .o_imem_req     (o_imem_req),
    .o_imem_addr    (o_imem_addr),
    .i_imem_gnt     (i_imem_gnt),
    .i_imem_rvalid  (i_imem_rvalid),
    .i_imem_rdata   (i_imem_rdata),
    .o_instr_valid  (o_instr_valid),
    .o_instruction  (o_instruction),
    .o_pc           (o_pc),
    .i_decode_ready (i_decode_ready),
    .i_redirect     (i_redirect),
    .i_redirect_pc  (i_redirect_pc)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic [31:0] target;
    logic [31:0] first_pc;
    logic [31:0] second_pc;
  } redir_vec_t;

  mreq_t       mq[$];
  redir_vec_t  vecs[5];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          pops  = 0;
  bit          gnt_off, gnt_rand, ready_off, ready_rand, lat_rand;
  int          lat_extra;
  bit          redirect_now;
  logic [31:0] redirect_target;
  logic [31:0] exp_pc, model_fetch, prev_addr, last_pop_pc, last_addr;
  bit          model_stale, prev_held, after_redirect, last_req;

  // Memory contents: a distinct word per aligned address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'h5A5A_0000) | 32'h0000_0003;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // One clock: check registered outputs, drive inputs, score the handshakes.
  task automatic applyStimulus();
    logic gfire, pop_now, held_now;
    @(negedge i_clk);
    last_req  = o_imem_req;
    last_addr = o_imem_addr;
    if (after_redirect) checkOutput("valid_after_redirect", 32'(o_instr_valid), 32'd0);
    if (prev_held) begin
      checkOutput("req_held", 32'(o_imem_req), 32'd1);
      checkOutput("addr_held", o_imem_addr, prev_addr);
    end else if (o_imem_req) begin
      checkOutput("req_addr", o_imem_addr, model_fetch);
    end
    if (o_imem_req) checkOutput("credit", 32'(mq.size() < DEPTH), 32'd1);

    i_imem_gnt     = gnt_off ? 1'b0 : (gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    i_decode_ready = ready_off ? 1'b0 : (ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
    if (mq.size() > 0 && mq[0].due <= cyc && (!lat_rand || $urandom_range(0, 2) != 0)) begin
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = mem_word(mq[0].addr);
    end else begin
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = $urandom;
    end
    i_redirect    = redirect_now;
    i_redirect_pc = redirect_target;
    redirect_now  = 1'b0;
    #1;

    gfire    = o_imem_req && i_imem_gnt;
    pop_now  = o_instr_valid && i_decode_ready;
    held_now = o_imem_req && !i_imem_gnt;
    if (pop_now) begin
      checkOutput("pop_pc", o_pc, exp_pc);
      checkOutput("pop_instr", o_instruction, mem_word(exp_pc));
      last_pop_pc = o_pc;
      exp_pc      = exp_pc + 32'd4;
      pops++;
    end
    if (i_redirect) begin
      model_fetch = {i_redirect_pc[31:2], 2'b00};
      exp_pc      = model_fetch;
      model_stale = held_now;
    end else if (gfire) begin
      if (model_stale) model_stale = 1'b0;
      else model_fetch = model_fetch + 32'd4;
    end
    prev_held      = held_now;
    prev_addr      = o_imem_addr;
    after_redirect = i_redirect;
    if (i_imem_rvalid) void'(mq.pop_front());
    if (gfire) mq.push_back('{addr: o_imem_addr,
                              due: cyc + 1 + lat_extra + (lat_rand ? int'($urandom_range(0, 3)) : 0)});
    cyc++;
  endtask

  task automatic doReset();
    @(negedge i_clk);
    i_rst_n        = 1'b0;
    i_imem_gnt     = 1'b0;
    i_imem_rvalid  = 1'b0;
    i_decode_ready = 1'b0;
    i_redirect     = 1'b0;
    #1;
    checkOutput("rst_req", 32'(o_imem_req), 32'd0);
    checkOutput("rst_addr", o_imem_addr, 32'h0);
    checkOutput("rst_valid", 32'(o_instr_valid), 32'd0);
    checkOutput("rst_instr", o_instruction, NOP);
    checkOutput("rst_pc", o_pc, 32'h0);
    mq.delete();
    cyc = 0; exp_pc = 32'h0; model_fetch = 32'h0;
    model_stale = 0; prev_held = 0; after_redirect = 0; redirect_now = 0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic waitPop(input int budget, input string name);
    int start;
    start = pops;
    for (int i = 0; i < budget && pops == start; i++) applyStimulus();
    checkOutput(name, 32'(pops != start), 32'd1);
  endtask

  initial begin
    int start;
    vecs[0] = '{32'h0000_0100, 32'h0000_0100, 32'h0000_0104};
    vecs[1] = '{32'h0000_0203, 32'h0000_0200, 32'h0000_0204};
    vecs[2] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[3] = '{32'h0000_8001, 32'h0000_8000, 32'h0000_8004};
    vecs[4] = '{32'h7FFF_FFFE, 32'h7FFF_FFFC, 32'h8000_0000};
    gnt_off = 0; gnt_rand = 0; ready_off = 0; ready_rand = 0; lat_rand = 0;
    lat_extra = 0; redirect_target = '0; last_pop_pc = '0;

    doReset();
    applyStimulus();
    applyStimulus();
    checkOutput("no_bypass", pops, 0);
    applyStimulus();
    checkOutput("first_latency", pops, 1);
    checkOutput("first_pc", last_pop_pc, 32'h0);
    repeat (20) applyStimulus();
    checkOutput("throughput", pops, 21);

    ready_off = 1;
    repeat (10) applyStimulus();
    checkOutput("stall_req_low", 32'(last_req), 32'd0);
    checkOutput("stall_inflight", mq.size(), 0);
    checkOutput("stall_buffered", (model_fetch - exp_pc) >> 2, DEPTH);
    ready_off = 0;
    start = pops;
    repeat (DEPTH) applyStimulus();
    checkOutput("stall_resume", pops - start, DEPTH);

    lat_extra = 3;
    repeat (6) applyStimulus();
    checkOutput("inflight_setup", 32'(mq.size() >= 2), 32'd1);
    redirect_now = 1; redirect_target = 32'h100;
    applyStimulus();
    lat_extra = 0;
    waitPop(30, "redirect_pop");
    checkOutput("redirect_first_pc", last_pop_pc, 32'h100);

    gnt_off = 1;
    repeat (4) applyStimulus();
    checkOutput("held_setup", 32'(last_req), 32'd1);
    redirect_now = 1; redirect_target = 32'h340;
    applyStimulus();
    repeat (2) applyStimulus();
    gnt_off = 0;
    applyStimulus();
    applyStimulus();
    checkOutput("post_held_addr", last_addr, 32'h340);
    waitPop(30, "held_redirect_pop");
    checkOutput("held_redirect_first_pc", last_pop_pc, 32'h340);

    for (int v = 0; v < 5; v++) begin
      redirect_now = 1; redirect_target = vecs[v].target;
      applyStimulus();
      applyStimulus();
      checkOutput("tbl_req_addr", last_addr, vecs[v].first_pc);
      waitPop(20, "tbl_pop1");
      checkOutput("tbl_first_pc", last_pop_pc, vecs[v].first_pc);
      waitPop(20, "tbl_pop2");
      checkOutput("tbl_second_pc", last_pop_pc, vecs[v].second_pc);
    end

    gnt_rand = 1; ready_rand = 1; lat_rand = 1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 29) == 0) begin
        redirect_now    = 1;
        redirect_target = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom;
      end
      applyStimulus();
    end
    gnt_rand = 0; ready_rand = 0; lat_rand = 0;
    start = pops;
    repeat (20) applyStimulus();
    checkOutput("drain_progress", 32'(pops > start), 32'd1);

    doReset();
    waitPop(10, "restart_pop");
    checkOutput("restart_pc", last_pop_pc, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the Argon RV32I core. Issues word-aligned requests to the instruction memory, buffers returned words with their PCs in a small prefetch FIFO, and presents them to `instruction_decode` (`i_pc`, `i_instruction`) over a valid/ready handshake. Handles control-flow redirects from execute by flushing the FIFO and discarding in-flight responses.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `FIFO_DEPTH`, 4: prefetch FIFO entries and maximum outstanding-plus-buffered words; power of two, ≥2.

Ports:
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `o_imem_req`  out  1  memory request valid.
- `o_imem_addr`  out  32  request byte address, bits [1:0] always 0.
- `i_imem_gnt`  in  1  request accepted this cycle when `o_imem_req`=1.
- `i_imem_rvalid`  in  1  response word valid; in-order, ≥1 cycle after its grant.
- `i_imem_rdata`  in  32  response instruction word.
- `o_instr_valid`  out  1  FIFO head valid toward decode.
- `o_instruction`  out  32  head instruction word.
- `o_pc`  out  32  head instruction PC.
- `i_decode_ready`  in  1  decode accepts head this cycle.
- `i_redirect`  in  1  taken jump/branch; flush and refetch.
- `i_redirect_pc`  in  32  new PC; bits [1:0] ignored (forced 0).

## Operation
- Registers: `fetch_pc` (next request address), `resp_pc` (PC of next accepted response), `outstanding` (granted, not yet returned), `discard` (responses to drop), FIFO of {pc, instr}.
- Issue condition: `outstanding + fifo_count < FIFO_DEPTH` on registered values; no same-cycle credit from pops or returns.
- Once `o_imem_req`=1, `o_imem_req` and `o_imem_addr` hold until `i_imem_gnt`, even across redirects (no retraction).
- On grant: `fetch_pc += 4`, `outstanding++`.
- On `i_imem_rvalid`: `outstanding--`. If `discard`>0, drop word and `discard--`; else push {`resp_pc`, `i_imem_rdata`}, `resp_pc += 4`.
- Pop when `o_instr_valid && i_decode_ready`.
- Redirect cycle: FIFO cleared; `fetch_pc` and `resp_pc` ← `{i_redirect_pc[31:2],2'b00}`; `discard` ← all requests granted and not yet returned, counting a grant in the same cycle and excluding a response returning in the same cycle (that response is itself dropped). A pending ungranted request is also added to `discard` when granted later. Same-cycle pop completes before the flush.
- Back-to-back redirects: each overwrites PCs; `discard` accumulates correctly.
- PC arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- No compressed instructions, no misalignment exception.

## Timing
- Reset values: `o_imem_req`=0, `o_imem_addr`=`RESET_PC`, `o_instr_valid`=0, `o_instruction`=32'h0000_0013 (NOP), `o_pc`=`RESET_PC`, all counters 0.
- First request in the first clock after `i_rst_n` deasserts.
- Minimum latency: grant at cycle N, `rvalid` at N+1, `o_instr_valid` at N+2 (no FIFO bypass).
- Redirect at cycle N: `o_instr_valid`=0 from N+1; request to new PC at N+1 unless an ungranted request is pending.
- With 1-cycle memory, `FIFO_DEPTH`=4 and decode always ready: one instruction per cycle sustained.
- Decode stall: requests stop once credit is exhausted; no overflow and no drops.
- Reset mid-operation: all state returns to reset values immediately; late memory responses are the memory's responsibility.

## Structure
- `RESET_PC` default and `NOP_INSTR` (32'h0000_0013) belong in the shared core package.
- One sub-module: `fetch_fifo`, a synchronous FIFO with parameterised width and depth, push, pop, flush, count, and registered head.

## Test plan
- Reset, 1-cycle memory, decode ready: requests to 0x0, 0x4, 0x8…; `o_pc` 0x0 first valid two cycles after the first grant, then one instruction per cycle.
- Decode ready low for 10 cycles: exactly `FIFO_DEPTH` words buffered, `o_imem_req` drops, order and PCs intact on resume.
- Redirect to 0x100 with 2 responses in flight: both dropped, first delivered `o_pc`=0x100, no stale word appears.
- Redirect while a request is held ungranted for 3 cycles: request address stable, its response dropped, next request to the redirect PC.
- Redirect to 0x203: fetch at 0x200. Redirect to 0xFFFF_FFFC: sequence 0xFFFF_FFFC, 0x0.
- Assert `i_rst_n`=0 mid-burst: all outputs at reset values next edge; restart from `RESET_PC`.
